inst_encoder: RTL and testbench

- Encoding counterpart of the core's control decoder. Takes field-level instruction requests (format class, funct3, registers, immediate) and packs them into legal RV32I/Zicsr 32-bit words.
- Streams each word with an auto-incrementing IMEM word address to the IMEM/BIOS program-load path.
- Used for self-test program generation and loader-driven patching.
- Runs one bounded job per start pulse, with a one-stage registered output and a valid/ready handshake on both sides.

---
 rtl/inst_encoder_pkg.sv | 41 ++++
 rtl/inst_pack.sv | 106 ++++++++++
 rtl/inst_encoder.sv | 151 +++++++++++++++
 tb/tb_inst_encoder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_encoder_pkg.sv
// Shared encoding constants for inst_encoder: format class codes, opcodes,
// the canonical NOP word, the alternate funct7 value and the FSM state type.
package inst_encoder_pkg;

   // Format class codes presented on req_fmt
   localparam logic [3:0] FMT_R      = 4'd0;
   localparam logic [3:0] FMT_I      = 4'd1;
   localparam logic [3:0] FMT_LOAD   = 4'd2;
   localparam logic [3:0] FMT_STORE  = 4'd3;
   localparam logic [3:0] FMT_BRANCH = 4'd4;
   localparam logic [3:0] FMT_LUI    = 4'd5;
   localparam logic [3:0] FMT_AUIPC  = 4'd6;
   localparam logic [3:0] FMT_JAL    = 4'd7;
   localparam logic [3:0] FMT_JALR   = 4'd8;
   localparam logic [3:0] FMT_CSR    = 4'd9;

   // addi x0,x0,0 -- emitted in place of any illegal request
   localparam logic [31:0] NOP = 32'h0000_0013;

   // funct7 for SUB / SRA / SRAI
   localparam logic [6:0] FUNCT7_ALT = 7'b0100000;

   // RV32I / Zicsr major opcodes
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational field packing and legality check for one request.
// Optional feature: define INST_ENC_CSR_EN to encode FMT_CSR as a SYSTEM
// instruction; otherwise FMT_CSR is treated as an illegal format.
module inst_pack
   import inst_encoder_pkg::*;
(
   input  logic [3:0]  fmt_i,
   input  logic [2:0]  funct3_i,
   input  logic        alt_i,
   input  logic [4:0]  rd_i,
   input  logic [4:0]  rs1_i,
   input  logic [4:0]  rs2_i,
   input  logic [31:0] imm_i,
   input  logic [11:0] csr_i,
   output logic [31:0] inst_o,
   output logic        illegal_o
);

   logic       fits12;
   logic       fits13;
   logic       fits21;
   logic       word_aligned;
   logic       shift_form;
   logic       alt_ok;
   logic [6:0] funct7;

   // Signed range checks: every bit above the sign bit must match it
   assign fits12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
   assign fits13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
   assign fits21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);
   // No compressed extension, so branch/jump targets must be word aligned
   assign word_aligned = (imm_i[1:0] == 2'b00);
   assign shift_form   = (funct3_i == 3'b001) || (funct3_i == 3'b101);
   assign funct7       = alt_i ? FUNCT7_ALT : 7'd0;
   // Only SUB/SRA and SRAI have an alternate funct7 encoding
   assign alt_ok = ~alt_i
                 | ((fmt_i == FMT_R) && ((funct3_i == 3'b000) || (funct3_i == 3'b101)))
                 | ((fmt_i == FMT_I) && (funct3_i == 3'b101));

`ifndef INST_ENC_CSR_EN
   logic unused_csr;
   assign unused_csr = ^csr_i;
`endif

   // Pack fields per format, then replace illegal requests with NOP
   always_comb begin
      inst_o    = NOP;
      illegal_o = 1'b0;
      case (fmt_i)
         FMT_R: begin
            inst_o = {funct7, rs2_i, rs1_i, funct3_i, rd_i, OPC_OP};
         end
         FMT_I: begin
            if (shift_form) begin
               if (imm_i[31:5] != 27'd0) illegal_o = 1'b1;
               inst_o = {funct7, imm_i[4:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
            end else begin
               if (!fits12) illegal_o = 1'b1;
               inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OP_IMM};
            end
         end
         FMT_LOAD: begin
            if (!fits12) illegal_o = 1'b1;
            inst_o = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
         end
         FMT_STORE: begin
            if (!fits12) illegal_o = 1'b1;
            inst_o = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
         end
         FMT_BRANCH: begin
            if (!fits13 || !word_aligned) illegal_o = 1'b1;
            inst_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                      imm_i[4:1], imm_i[11], OPC_BRANCH};
         end
         FMT_LUI: begin
            if (imm_i[11:0] != 12'd0) illegal_o = 1'b1;
            inst_o = {imm_i[31:12], rd_i, OPC_LUI};
         end
         FMT_AUIPC: begin
            if (imm_i[11:0] != 12'd0) illegal_o = 1'b1;
            inst_o = {imm_i[31:12], rd_i, OPC_AUIPC};
         end
         FMT_JAL: begin
            if (!fits21 || !word_aligned) illegal_o = 1'b1;
            inst_o = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
         end
         FMT_JALR: begin
            if (!fits12) illegal_o = 1'b1;
            inst_o = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
         end
`ifdef INST_ENC_CSR_EN
         FMT_CSR: begin
            // funct3 000 is ECALL/EBREAK space and 100 is reserved
            if ((funct3_i == 3'b000) || (funct3_i == 3'b100)) illegal_o = 1'b1;
            inst_o = {csr_i, rs1_i, funct3_i, rd_i, OPC_SYSTEM};
         end
`endif
         default: begin
            illegal_o = 1'b1;
         end
      endcase
      if (!alt_ok) illegal_o = 1'b1;
      if (illegal_o) inst_o = NOP;
   end

endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: runs one bounded encode job per start pulse, streaming packed
// RV32I/Zicsr words with auto-incrementing IMEM word addresses through a
// single registered output stage. CSR encoding is enabled by INST_ENC_CSR_EN.
module inst_encoder
   import inst_encoder_pkg::*;
#(
   parameter int ADDR_WIDTH = 14,
   parameter int CNT_WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  count,
   input  logic                  abort,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [3:0]            req_fmt,
   input  logic [2:0]            req_funct3,
   input  logic                  req_alt,
   input  logic [4:0]            req_rd,
   input  logic [4:0]            req_rs1,
   input  logic [4:0]            req_rs2,
   input  logic [31:0]           req_imm,
   input  logic [11:0]           req_csr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [31:0]           out_inst,
   output logic [ADDR_WIDTH-1:0] out_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   state_e                state_q, state_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                  out_valid_q, out_valid_d;
   logic [31:0]           out_inst_q, out_inst_d;
   logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;

   logic [31:0]           packed_inst;
   logic                  packed_illegal;
   logic                  accept;

   inst_pack u_pack (
      .fmt_i     (req_fmt),
      .funct3_i  (req_funct3),
      .alt_i     (req_alt),
      .rd_i      (req_rd),
      .rs1_i     (req_rs1),
      .rs2_i     (req_rs2),
      .imm_i     (req_imm),
      .csr_i     (req_csr),
      .inst_o    (packed_inst),
      .illegal_o (packed_illegal)
   );

   // Accept only when the output slot is free or emptying this cycle
   assign req_ready = (state_q == ST_RUN) && (remaining_q != '0)
                    && (~out_valid_q || out_ready) && ~abort;
   assign accept    = req_valid && req_ready;

   // Abort kills a pending word combinationally so the sink never takes it
   assign out_valid = out_valid_q & ~abort;
   assign out_inst  = out_inst_q;
   assign out_addr  = out_addr_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign err       = err_q;

   // Next-state: job sequencing, address/count bookkeeping, output stage
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      addr_d      = addr_q;
      out_valid_d = out_valid_q;
      out_inst_d  = out_inst_q;
      out_addr_d  = out_addr_q;
      done_d      = 1'b0;
      err_d       = err_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               err_d = 1'b0;
               if (count != '0) begin
                  state_d     = ST_RUN;
                  remaining_d = count;
                  addr_d      = base_addr;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end else if (accept) begin
               out_valid_d = 1'b1;
               out_inst_d  = packed_inst;
               out_addr_d  = addr_q;
               addr_d      = addr_q + ADDR_WIDTH'(1);
               remaining_d = remaining_q - CNT_WIDTH'(1);
               if (packed_illegal) err_d = 1'b1;
               if (remaining_q == CNT_WIDTH'(1)) state_d = ST_DRAIN;
            end else if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         ST_DRAIN: begin
            if (abort || !out_valid_q || out_ready) begin
               state_d     = ST_IDLE;
               out_valid_d = 1'b0;
               done_d      = 1'b1;
            end
         end
         default: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         addr_q      <= '0;
         out_valid_q <= 1'b0;
         out_inst_q  <= '0;
         out_addr_q  <= '0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         addr_q      <= addr_d;
         out_valid_q <= out_valid_d;
         out_inst_q  <= out_inst_d;
         out_addr_q  <= out_addr_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_inst_encoder.sv
// Directed testbench for inst_encoder with hand-computed expected words.
// Expected CSR results depend on whether INST_ENC_CSR_EN is defined.
module tb_inst_encoder;
   import inst_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic [13:0] base_addr;
   logic [13:0] count;
   logic        abort;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_fmt;
   logic [2:0]  req_funct3;
   logic        req_alt;
   logic [4:0]  req_rd;
   logic [4:0]  req_rs1;
   logic [4:0]  req_rs2;
   logic [31:0] req_imm;
   logic [11:0] req_csr;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [13:0] out_addr;
   logic        busy;
   logic        done;
   logic        err;

   int errors = 0;
   int checks = 0;

   inst_encoder #(.ADDR_WIDTH(14), .CNT_WIDTH(14)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .count      (count),
      .abort      (abort),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_fmt    (req_fmt),
      .req_funct3 (req_funct3),
      .req_alt    (req_alt),
      .req_rd     (req_rd),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_imm    (req_imm),
      .req_csr    (req_csr),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_inst   (out_inst),
      .out_addr   (out_addr),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [13:0] b, input logic [13:0] c);
      start     = 1'b1;
      base_addr = b;
      count     = c;
      tick();
      start     = 1'b0;
   endtask

   task automatic set_req(input logic [3:0] f, input logic [2:0] f3, input logic alt,
                          input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [31:0] imm, input logic [11:0] csr);
      req_valid  = 1'b1;
      req_fmt    = f;
      req_funct3 = f3;
      req_alt    = alt;
      req_rd     = rd;
      req_rs1    = rs1;
      req_rs2    = rs2;
      req_imm    = imm;
      req_csr    = csr;
      #1;
   endtask

   task automatic clear_req();
      req_valid = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_out_inst: got %h want 00000000", out_inst); end
      checks++; if (out_addr !== 14'h0) begin errors++; $display("FAIL reset_out_addr: got %h want 0000", out_addr); end
      checks++; if ({busy, done, err, req_ready} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, err, req_ready}); end
   endtask

   task automatic test_addi();
      do_start(14'h100, 14'd1);
      out_ready = 1'b1;
      set_req(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 12'd0);
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL addi_req_ready: got %b want 1", req_ready); end
      tick();
      clear_req();
      $display("txn addi addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL addi_valid: got %b want 1", out_valid); end
      checks++; if (out_inst !== 32'h0050_0093) begin errors++; $display("FAIL addi_inst: got %h want 00500093", out_inst); end
      checks++; if (out_addr !== 14'h100) begin errors++; $display("FAIL addi_addr: got %h want 0100", out_addr); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_early: got %b want 0", done); end
      tick();
      checks++; if ({done, busy, out_valid, err} !== 4'b1000) begin errors++; $display("FAIL addi_done: got done/busy/valid/err=%b want 1000", {done, busy, out_valid, err}); end
      tick();
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL addi_done_pulse: got %b want 0", done); end
   endtask

   task automatic test_back_to_back();
      do_start(14'h020, 14'd2);
      out_ready = 1'b0;
      set_req(FMT_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, 12'd0);
      tick();
      set_req(FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 12'd0);
      for (int i = 0; i < 3; i++) begin
         start     = (i == 0);
         base_addr = 14'h3000;
         count     = 14'd9;
         #1;
         checks++; if (out_inst !== 32'h4020_81B3 || out_addr !== 14'h020 || out_valid !== 1'b1) begin
            errors++; $display("FAIL stall_hold%0d: got inst=%h addr=%h valid=%b want 402081b3 0020 1", i, out_inst, out_addr, out_valid);
         end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %b want 0", i, req_ready); end
         tick();
      end
      start = 1'b0;
      $display("txn sub addr=%h inst=%h", out_addr, out_inst);
      out_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", req_ready); end
      tick();
      clear_req();
      $display("txn beq addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== 32'h0020_8463) begin errors++; $display("FAIL beq_inst: got %h want 00208463", out_inst); end
      checks++; if (out_addr !== 14'h021) begin errors++; $display("FAIL beq_addr: got %h want 0021", out_addr); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got %b want 1", done); end
   endtask

   task automatic test_jal_lui();
      do_start(14'h000, 14'd2);
      out_ready = 1'b1;
      set_req(FMT_JAL, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 12'd0);
      tick();
      set_req(FMT_LUI, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'h1234_5000, 12'd0);
      $display("txn jal addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== 32'h0010_00EF || out_addr !== 14'h000) begin errors++; $display("FAIL jal_inst: got %h@%h want 001000ef@0000", out_inst, out_addr); end
      tick();
      clear_req();
      $display("txn lui addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== 32'h1234_5137 || out_addr !== 14'h001) begin errors++; $display("FAIL lui_inst: got %h@%h want 12345137@0001", out_inst, out_addr); end
      tick();
      checks++; if (done !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL jal_lui_done: got done=%b err=%b want 1 0", done, err); end
   endtask

   task automatic test_shift_store();
      do_start(14'h040, 14'd2);
      out_ready = 1'b1;
      set_req(FMT_I, 3'b101, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, 12'd0);
      tick();
      set_req(FMT_STORE, 3'b010, 1'b0, 5'd0, 5'd1, 5'd2, 32'd12, 12'd0);
      $display("txn srai addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== 32'h4033_5293) begin errors++; $display("FAIL srai_inst: got %h want 40335293", out_inst); end
      tick();
      clear_req();
      $display("txn sw addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== 32'h0020_A623) begin errors++; $display("FAIL sw_inst: got %h want 0020a623", out_inst); end
      tick();
   endtask

   task automatic test_illegal();
      do_start(14'h050, 14'd2);
      out_ready = 1'b1;
      set_req(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 12'd0);
      tick();
      set_req(FMT_BRANCH, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd6, 12'd0);
      $display("txn bad_addi addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== NOP || err !== 1'b1) begin errors++; $display("FAIL illegal_addi: got inst=%h err=%b want 00000013 1", out_inst, err); end
      tick();
      clear_req();
      $display("txn bad_beq addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== NOP || out_addr !== 14'h051) begin errors++; $display("FAIL illegal_beq: got %h@%h want 00000013@0051", out_inst, out_addr); end
      tick();
      checks++; if (done !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL illegal_sticky: got done=%b err=%b want 1 1", done, err); end
      tick();
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL illegal_sticky_idle: got %b want 1", err); end
   endtask

   task automatic test_csr();
      logic [31:0] exp_inst;
      logic        exp_err;
`ifdef INST_ENC_CSR_EN
      exp_inst = 32'h51E2_9073;
      exp_err  = 1'b0;
`else
      exp_inst = NOP;
      exp_err  = 1'b1;
`endif
      do_start(14'h060, 14'd1);
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear_on_start: got %b want 0", err); end
      out_ready = 1'b1;
      set_req(FMT_CSR, 3'b001, 1'b0, 5'd0, 5'd5, 5'd0, 32'd0, 12'h51E);
      tick();
      clear_req();
      $display("txn csrrw addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_inst !== exp_inst || err !== exp_err) begin errors++; $display("FAIL csr_inst: got %h err=%b want %h err=%b", out_inst, err, exp_inst, exp_err); end
      tick();
   endtask

   task automatic test_abort_wrap();
      do_start(14'h010, 14'd4);
      out_ready = 1'b1;
      set_req(FMT_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 12'd0);
      tick();
      set_req(FMT_I, 3'b000, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, 12'd0);
      tick();
      clear_req();
      out_ready = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b1 || out_addr !== 14'h011) begin errors++; $display("FAIL abort_pending: got valid=%b addr=%h want 1 0011", out_valid, out_addr); end
      abort = 1'b1;
      #1;
      checks++; if (out_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL abort_immediate: got valid=%b ready=%b want 0 0", out_valid, req_ready); end
      tick();
      abort = 1'b0;
      #1;
      $display("txn abort busy=%b done=%b", busy, done);
      checks++; if ({done, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL abort_done: got done/busy/valid=%b want 100", {done, busy, out_valid}); end
      do_start(14'h3FFF, 14'd2);
      out_ready = 1'b1;
      set_req(FMT_I, 3'b000, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, 12'd0);
      tick();
      set_req(FMT_I, 3'b000, 1'b0, 5'd4, 5'd0, 5'd0, 32'd4, 12'd0);
      $display("txn wrap0 addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_addr !== 14'h3FFF || out_inst !== 32'h0030_0193) begin errors++; $display("FAIL wrap_first: got %h@%h want 00300193@3fff", out_inst, out_addr); end
      tick();
      clear_req();
      $display("txn wrap1 addr=%h inst=%h", out_addr, out_inst);
      checks++; if (out_addr !== 14'h0000 || out_inst !== 32'h0040_0213) begin errors++; $display("FAIL wrap_second: got %h@%h want 00400213@0000", out_inst, out_addr); end
      tick();
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL wrap_done: got %b want 1", done); end
   endtask

   task automatic test_zero_count();
      do_start(14'h070, 14'd0);
      $display("txn zero_count busy=%b done=%b", busy, done);
      checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL zero_done: got done=%b busy=%b want 1 0", done, busy); end
      tick();
      checks++; if (done !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL zero_after: got done=%b valid=%b want 0 0", done, out_valid); end
   endtask

   initial begin
      rst_n      = 1'b0;
      start      = 1'b0;
      base_addr  = '0;
      count      = '0;
      abort      = 1'b0;
      req_valid  = 1'b0;
      req_fmt    = '0;
      req_funct3 = '0;
      req_alt    = 1'b0;
      req_rd     = '0;
      req_rs1    = '0;
      req_rs2    = '0;
      req_imm    = '0;
      req_csr    = '0;
      out_ready  = 1'b0;
      #2;
      test_reset();
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      test_reset();
      test_addi();
      test_back_to_back();
      test_jal_lui();
      test_shift_store();
      test_illegal();
      test_csr();
      test_abort_wrap();
      test_zero_count();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the bench always terminates
   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
